fact_ctrl: RTL and testbench

Recursive-factorial controller that sits directly upstream of the team's 3-entry `Stack` and drives its `R_W`/`PUSH` ports while consuming `POP`. On `start` it unwinds n! by pushing n, n-1, …, 2 onto the stack. It then pops each value and multiplies it into an accumulator, and reports the 32-bit result with a one-cycle `done` pulse. Depth overflow is detected before any stack traffic.

---
 rtl/fact_ctrl.sv | 173 +++++++++++++++++
 tb/tb_fact_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fact_ctrl.sv
// fact_ctrl -- recursive-factorial controller driving an external LIFO stack.
//
// On start it pushes n, n-1, ..., 2 onto the attached stack, then pops each
// value back and multiplies it into a 32-bit accumulator. The product
// (n! mod 2^32) is reported with a one-cycle done pulse. An operand too large
// for the stack depth is rejected up front with overflow set, before any
// stack command is issued.
//
// Parameters:
//   DEPTH       usable entries in the attached stack; largest accepted n is DEPTH+1
// Ports:
//   clk         clock, rising edge
//   rst_n       synchronous active-low reset
//   start       run request, sampled only in IDLE
//   n           4-bit operand, sampled with start
//   busy        high in every state except IDLE
//   done        one-cycle completion pulse
//   overflow    valid with done: operand exceeded DEPTH+1
//   result      n! mod 2^32, held until the next accepted start
//   stack_rw    stack command: 0 = push, 1 = pop, 2 = idle
//   stack_push  data written to the stack on a push
//   stack_pop   stack read data, valid the cycle after a pop command
module fact_ctrl #(
  parameter int DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  n,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [31:0] result,
  output logic [1:0]  stack_rw,
  output logic [31:0] stack_push,
  input  logic [31:0] stack_pop
);

  localparam int DW   = (DEPTH < 2) ? 1 : $clog2(DEPTH + 1);
  localparam int NMAX = DEPTH + 1;

  localparam logic [1:0] RW_PUSH = 2'd0;
  localparam logic [1:0] RW_POP  = 2'd1;
  localparam logic [1:0] RW_IDLE = 2'd2;

  typedef enum logic [2:0] {
    S_DRAIN,
    S_IDLE,
    S_PUSH,
    S_POP,
    S_MUL,
    S_DONE
  } state_t;

  state_t         state_reg, state_next;
  logic [DW-1:0]  drain_cnt_reg, drain_cnt_next;
  logic [3:0]     cnt_reg, cnt_next;
  logic [3:0]     pend_reg, pend_next;
  logic [31:0]    acc_reg, acc_next;
  logic [31:0]    result_reg, result_next;
  logic           overflow_reg, overflow_next;
  logic [31:0]    product;
  logic           too_big;

  // Truncating multiply: only the low 32 bits of the product are kept.
  assign product = acc_reg * stack_pop;
  assign too_big = (int'(n) > NMAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_DRAIN;
      drain_cnt_reg <= DW'(DEPTH);
      cnt_reg       <= '0;
      pend_reg      <= '0;
      acc_reg       <= '0;
      result_reg    <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      drain_cnt_reg <= drain_cnt_next;
      cnt_reg       <= cnt_next;
      pend_reg      <= pend_next;
      acc_reg       <= acc_next;
      result_reg    <= result_next;
      overflow_reg  <= overflow_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    drain_cnt_next = drain_cnt_reg;
    cnt_next       = cnt_reg;
    pend_next      = pend_reg;
    acc_next       = acc_reg;
    result_next    = result_reg;
    overflow_next  = overflow_reg;
    stack_rw       = RW_IDLE;
    stack_push     = '0;

    case (state_reg)
      // The stack itself has no reset, so after every reset we blindly pop
      // DEPTH times to discard whatever an interrupted run left behind.
      S_DRAIN: begin
        stack_rw       = RW_POP;
        drain_cnt_next = drain_cnt_reg - 1'b1;
        if (drain_cnt_reg <= DW'(1)) begin
          state_next = S_IDLE;
        end
      end

      S_IDLE: begin
        if (start) begin
          if (too_big) begin
            overflow_next = 1'b1;
            result_next   = '0;
            state_next    = S_DONE;
          end else if (n <= 4'd1) begin
            overflow_next = 1'b0;
            result_next   = 32'd1;
            state_next    = S_DONE;
          end else begin
            overflow_next = 1'b0;
            acc_next      = 32'd1;
            cnt_next      = n;
            pend_next     = n - 4'd1;
            state_next    = S_PUSH;
          end
        end
      end

      // Factor 1 is never pushed, so n-1 values go onto the stack.
      S_PUSH: begin
        stack_rw   = RW_PUSH;
        stack_push = {28'd0, cnt_reg};
        cnt_next   = cnt_reg - 4'd1;
        if (cnt_reg == 4'd2) begin
          state_next = S_POP;
        end
      end

      S_POP: begin
        stack_rw   = RW_POP;
        state_next = S_MUL;
      end

      // stack_pop carries the value requested in the preceding POP cycle.
      S_MUL: begin
        acc_next  = product;
        pend_next = pend_reg - 4'd1;
        if (pend_reg == 4'd1) begin
          result_next = product;
          state_next  = S_DONE;
        end else begin
          state_next = S_POP;
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_DRAIN;
      end
    endcase
  end

  assign busy     = (state_reg != S_IDLE);
  assign done     = (state_reg == S_DONE);
  assign overflow = overflow_reg;
  assign result   = result_reg;

endmodule

// File: tb/tb_fact_ctrl.sv
// Bench for fact_ctrl: two instances (DEPTH=3 and DEPTH=12), each attached to
// a behavioural LIFO stack. Stimulus pushes expected responses into a
// per-instance queue; a monitor per instance pops and checks on every done.
module tb_fact_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_a, start_b;
  logic [3:0]  n_a, n_b;
  logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
  logic [31:0] result_a, result_b;
  logic [1:0]  rw_a, rw_b;
  logic [31:0] push_a, push_b, pop_a, pop_b;

  fact_ctrl #(.DEPTH(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .n(n_a),
    .busy(busy_a), .done(done_a), .overflow(ovf_a), .result(result_a),
    .stack_rw(rw_a), .stack_push(push_a), .stack_pop(pop_a)
  );

  fact_ctrl #(.DEPTH(12)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .n(n_b),
    .busy(busy_b), .done(done_b), .overflow(ovf_b), .result(result_b),
    .stack_rw(rw_b), .stack_push(push_b), .stack_pop(pop_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    int          s;
    int          lat;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, req);
    end
  endtask

  // Behavioural stacks: push writes at the edge ending the push cycle; a pop
  // registers the top entry so it is visible the following cycle. Pops on an
  // empty stack leave the output unchanged.
  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];
  int sp_a = 0, sp_b = 0;
  int pushes_a = 0, pops_a = 0, pushes_b = 0, pops_b = 0;
  int push_val_a[$];
  int push_cyc_a[$];

  always @(posedge clk) begin
    if (rw_a == 2'd0) begin
      if (sp_a < 3) begin
        mem_a[sp_a] <= push_a;
        sp_a <= sp_a + 1;
      end
      pushes_a <= pushes_a + 1;
      push_val_a.push_back(int'(push_a));
      push_cyc_a.push_back(cyc);
    end else if (rw_a == 2'd1) begin
      if (sp_a > 0) begin
        pop_a <= mem_a[sp_a-1];
        sp_a <= sp_a - 1;
      end
      pops_a <= pops_a + 1;
    end
  end

  always @(posedge clk) begin
    if (rw_b == 2'd0) begin
      if (sp_b < 12) begin
        mem_b[sp_b] <= push_b;
        sp_b <= sp_b + 1;
      end
      pushes_b <= pushes_b + 1;
    end else if (rw_b == 2'd1) begin
      if (sp_b > 0) begin
        pop_b <= mem_b[sp_b-1];
        sp_b <= sp_b - 1;
      end
      pops_b <= pops_b + 1;
    end
  end

  // Monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done_a === 1'b1) begin
      exp_t e;
      if (sb_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done_a got result=%0h want no done", result_a);
      end else begin
        e = sb_a.pop_front();
        $display("txn A: result=%0h overflow=%0b latency=%0d", result_a, ovf_a, cyc - e.s);
        chk("result_a", result_a, e.res);
        chk("overflow_a", 32'(ovf_a), 32'(e.ovf));
        chk("latency_a", 32'(cyc - e.s), 32'(e.lat));
      end
    end
  end

  always @(negedge clk) begin
    if (done_b === 1'b1) begin
      exp_t e;
      if (sb_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done_b got result=%0h want no done", result_b);
      end else begin
        e = sb_b.pop_front();
        $display("txn B: result=%0h overflow=%0b latency=%0d", result_b, ovf_b, cyc - e.s);
        chk("result_b", result_b, e.res);
        chk("overflow_b", 32'(ovf_b), 32'(e.ovf));
        chk("latency_b", 32'(cyc - e.s), 32'(e.lat));
      end
    end
  end

  int last_s_a = 0;

  task automatic wait_idle_a();
    int i = 0;
    while (busy_a !== 1'b0 && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (i >= 200) begin
      checks++;
      errors++;
      $display("FAIL timeout_idle_a got busy=%b want 0", busy_a);
    end
  endtask

  task automatic wait_idle_b();
    int i = 0;
    while (busy_b !== 1'b0 && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (i >= 200) begin
      checks++;
      errors++;
      $display("FAIL timeout_idle_b got busy=%b want 0", busy_b);
    end
  endtask

  // Issue a start on A from IDLE; E0 is the next rising edge.
  task automatic go_a(input logic [3:0] nv, input bit expect_done,
                      input logic [31:0] er, input logic eo, input int el);
    exp_t e;
    wait_idle_a();
    start_a  = 1'b1;
    n_a      = nv;
    last_s_a = cyc + 1;
    if (expect_done) begin
      e.res = er; e.ovf = eo; e.s = cyc + 1; e.lat = el;
      sb_a.push_back(e);
    end
    @(negedge clk);
    start_a = 1'b0;
    n_a     = 4'd0;
  endtask

  // Called at a negedge with rst_n just released: count pop cycles until IDLE.
  task automatic check_drain_a(input string nm);
    int k = 0;
    int i = 0;
    while (busy_a !== 1'b0 && i < 50) begin
      if (rw_a == 2'd1) k++;
      @(negedge clk);
      i++;
    end
    chk({nm, "_pops"}, 32'(k), 32'd3);
    chk({nm, "_busy"}, 32'(busy_a), 32'd0);
  endtask

  initial begin
    int pb, pp;
    exp_t e;
    rst_n = 1'b0;
    start_a = 1'b0; n_a = 4'd0;
    start_b = 1'b0; n_b = 4'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset release: DEPTH pops, then IDLE with cleared outputs.
    check_drain_a("drain_reset");
    chk("reset_result", result_a, 32'd0);
    chk("reset_done", 32'(done_a), 32'd0);
    chk("reset_overflow", 32'(ovf_a), 32'd0);

    // n=4: pushes 4,3,2 on consecutive cycles, 3 pops, 24 after 9 cycles.
    pb = pushes_a; pp = pops_a;
    push_val_a.delete();
    push_cyc_a.delete();
    go_a(4'd4, 1'b1, 32'd24, 1'b0, 9);
    wait_idle_a();
    chk("n4_push_count", 32'(pushes_a - pb), 32'd3);
    chk("n4_pop_count", 32'(pops_a - pp), 32'd3);
    if (push_val_a.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("n4_push_value", 32'(push_val_a[i]), 32'(4 - i));
        chk("n4_push_cycle", 32'(push_cyc_a[i]), 32'(last_s_a + i));
      end
    end else begin
      chk("n4_push_log_size", 32'(push_val_a.size()), 32'd3);
    end
    chk("n4_stack_empty", 32'(sp_a), 32'd0);
    chk("n4_result_held", result_a, 32'd24);

    // n=0 and n=1: immediate done with 1, no stack traffic.
    pb = pushes_a; pp = pops_a;
    go_a(4'd0, 1'b1, 32'd1, 1'b0, 0);
    wait_idle_a();
    go_a(4'd1, 1'b1, 32'd1, 1'b0, 0);
    wait_idle_a();
    chk("n01_stack_cmds", 32'((pushes_a - pb) + (pops_a - pp)), 32'd0);

    // n=5 at DEPTH=3: overflow, result 0, no stack traffic.
    pb = pushes_a; pp = pops_a;
    go_a(4'd5, 1'b1, 32'd0, 1'b1, 0);
    wait_idle_a();
    chk("ovf_stack_cmds", 32'((pushes_a - pb) + (pops_a - pp)), 32'd0);
    chk("ovf_held", 32'(ovf_a), 32'd1);

    // Reset during the third push cycle of an n=4 run: no done, DRAIN cleans up.
    go_a(4'd4, 1'b0, 32'd0, 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_drain_a("drain_abort");
    chk("abort_stack_empty", 32'(sp_a), 32'd0);

    // A fresh n=3 run after the abort must see a clean stack.
    go_a(4'd3, 1'b1, 32'd6, 1'b0, 6);
    wait_idle_a();

    // DEPTH=12, n=13: 13! = 6227020800, mod 2^32 = 0x7328CC00, 36 cycles.
    wait_idle_b();
    e.res = 32'h7328CC00; e.ovf = 1'b0; e.lat = 36;
    start_b = 1'b1;
    n_b     = 4'd13;
    e.s     = cyc + 1;
    sb_b.push_back(e);
    @(negedge clk);
    start_b = 1'b0;
    n_b     = 4'd0;
    wait_idle_b();
    chk("n13_stack_empty", 32'(sp_b), 32'd0);

    @(negedge clk);
    chk("sb_a_drained", 32'(sb_a.size()), 32'd0);
    chk("sb_b_drained", 32'(sb_b.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
